// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter.
//   ramstate_t  : RAM status encoding seen on the ramstate input.
//   arb_state_t : arbiter FSM states.
//   grant_t     : which cache side owns the RAM port.
//   rr_pick     : round-robin choice between pending D and I requests.
package cache_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      D_SERV   = 2'd1,
      I_SERV   = 2'd2,
      ERR_DONE = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   localparam int unsigned WORD_W_DEF   = 32;
   localparam logic [31:0] ERR_WORD_DEF = 32'hBAD1BAD1;

   // D wins when it is the only requester or when I held the last grant.
   // Only meaningful when at least one side is pending.
   function automatic grant_t rr_pick(input logic d_pend, input logic i_pend,
                                      input grant_t last);
      if (d_pend && (!i_pend || last == GRANT_I)) return GRANT_D;
      return GRANT_I;
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundles around the arbiter.
//   cache_mem_if : icache/dcache request side. master = caches, slave = arbiter.
//     iREN/iaddr, dREN/dWEN/daddr/dstore requests; iwait/iload, dwait/dload replies.
//   ram_if       : single RAM port. master = arbiter, slave = RAM model.
//     ramREN/ramWEN/ramaddr/ramstore commands; ramload/ramstate replies.
interface cache_mem_if #(parameter int unsigned WORD_W = 32);
   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              iwait;
   logic [WORD_W-1:0] iload;
   logic              dREN;
   logic              dWEN;
   logic [WORD_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              dwait;
   logic [WORD_W-1:0] dload;

   modport master (output iREN, iaddr, dREN, dWEN, daddr, dstore,
                   input  iwait, iload, dwait, dload);
   modport slave  (input  iREN, iaddr, dREN, dWEN, daddr, dstore,
                   output iwait, iload, dwait, dload);
endinterface

interface ram_if #(parameter int unsigned WORD_W = 32);
   logic              ramREN;
   logic              ramWEN;
   logic [WORD_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   logic [1:0]        ramstate;

   modport master (output ramREN, ramWEN, ramaddr, ramstore,
                   input  ramload, ramstate);
   modport slave  (input  ramREN, ramWEN, ramaddr, ramstore,
                   output ramload, ramstate);
endinterface

// File: rtl/cache_mem_arbiter_timeout.sv
// Service-time watchdog for the arbiter.
//   CLK, RST   : clock, synchronous active-high reset
//   clear_i    : restart the count (asserted on the grant cycle)
//   enable_i   : count one service cycle
//   expired_o  : count has reached TIMEOUT_CYCLES-1 (saturates there)
module arb_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned   CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)                       cnt_d = '0;
      else if (enable_i && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Memory-side responder: serialises icache fetches and dcache reads/writes
// onto one variable-latency RAM port with round-robin fairness.
//   CLK, RST : clock, synchronous active-high reset
//   cache    : cache-side requests and iwait/iload, dwait/dload replies
//   ram      : RAM command port and ramload/ramstate status
//   mem_err  : sticky flag, set on RAM ERROR or service timeout
// A grant taken in IDLE drives the RAM from latched registers on the next
// cycle; every completion is followed by at least one IDLE cycle.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int unsigned       WORD_W         = WORD_W_DEF,
   parameter int unsigned       TIMEOUT_CYCLES = 64,
   parameter logic [WORD_W-1:0] ERR_WORD       = WORD_W'(ERR_WORD_DEF)
) (
   input  logic       CLK,
   input  logic       RST,
   cache_mem_if.slave cache,
   ram_if.master      ram,
   output logic       mem_err
);

   arb_state_t        state_q;
   grant_t            last_grant_q;
   logic              ramREN_q, ramWEN_q;
   logic [WORD_W-1:0] ramaddr_q, ramstore_q;
   logic [WORD_W-1:0] iload_q, dload_q, iload_d, dload_d;
   logic              mem_err_q;

   ramstate_t rs;
   grant_t    pick;
   logic      d_pend, i_pend, in_serv, owner_en;
   logic      d_done, i_done, d_err, i_err;
   logic      tmo_clear, tmo_expired;

   assign rs       = ramstate_t'(ram.ramstate);
   assign d_pend   = cache.dREN | cache.dWEN;
   assign i_pend   = cache.iREN;
   assign pick     = rr_pick(d_pend, i_pend, last_grant_q);
   assign in_serv  = (state_q == D_SERV) || (state_q == I_SERV);
   assign owner_en = (state_q == D_SERV) ? d_pend : i_pend;

   // Completion is combinational on ACCESS; error completion comes from the
   // one-cycle ERR_DONE state, whose owner is the last grant.
   assign d_done = (state_q == D_SERV) && (rs == ACCESS);
   assign i_done = (state_q == I_SERV) && (rs == ACCESS);
   assign d_err  = (state_q == ERR_DONE) && (last_grant_q == GRANT_D);
   assign i_err  = (state_q == ERR_DONE) && (last_grant_q == GRANT_I);

   assign tmo_clear = (state_q == IDLE) && (d_pend || i_pend);

   arb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
      .CLK       (CLK),
      .RST       (RST),
      .clear_i   (tmo_clear),
      .enable_i  (in_serv),
      .expired_o (tmo_expired)
   );

   // Loads pass the completing value straight through and otherwise hold.
   // ramWEN_q doubles as the latched D op for the whole service.
   always_comb begin
      iload_d = iload_q;
      dload_d = dload_q;
      if (i_done)                  iload_d = ram.ramload;
      else if (i_err)              iload_d = ERR_WORD;
      if (d_done && !ramWEN_q)     dload_d = ram.ramload;
      else if (d_err)              dload_d = ERR_WORD;
   end

   assign cache.iwait  = !(i_done || i_err);
   assign cache.dwait  = !(d_done || d_err);
   assign cache.iload  = iload_d;
   assign cache.dload  = dload_d;
   assign ram.ramREN   = ramREN_q;
   assign ram.ramWEN   = ramWEN_q;
   assign ram.ramaddr  = ramaddr_q;
   assign ram.ramstore = ramstore_q;
   assign mem_err      = mem_err_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_I;
         ramREN_q     <= 1'b0;
         ramWEN_q     <= 1'b0;
         ramaddr_q    <= '0;
         ramstore_q   <= '0;
         iload_q      <= '0;
         dload_q      <= '0;
         mem_err_q    <= 1'b0;
      end else begin
         iload_q <= iload_d;
         dload_q <= dload_d;
         case (state_q)
            IDLE: begin
               if (d_pend || i_pend) begin
                  last_grant_q <= pick;
                  if (pick == GRANT_D) begin
                     state_q    <= D_SERV;
                     ramaddr_q  <= cache.daddr;
                     ramstore_q <= cache.dstore;
                     // write wins when both dREN and dWEN are up
                     ramWEN_q   <= cache.dWEN;
                     ramREN_q   <= !cache.dWEN;
                  end else begin
                     state_q   <= I_SERV;
                     ramaddr_q <= cache.iaddr;
                     ramREN_q  <= 1'b1;
                     ramWEN_q  <= 1'b0;
                  end
               end
            end
            D_SERV, I_SERV: begin
               // ACCESS outranks an abort in the same cycle; abort outranks error
               if (rs == ACCESS || !owner_en) begin
                  state_q  <= IDLE;
                  ramREN_q <= 1'b0;
                  ramWEN_q <= 1'b0;
               end else if (rs == ERROR || tmo_expired) begin
                  state_q   <= ERR_DONE;
                  ramREN_q  <= 1'b0;
                  ramWEN_q  <= 1'b0;
                  mem_err_q <= 1'b1;
               end
            end
            ERR_DONE: state_q <= IDLE;
            default:  state_q <= IDLE;
         endcase
      end
   end

endmodule
